rr_mux_reg: RTL and testbench

- Parametrised N-way successor to the fixed 2/3-input operand muxes.
- Merges N valid/ready source channels into one registered output channel using round-robin arbitration.
- Used where several issue or functional-unit result ports share one writeback or commit port in the superscalar pipeline.
- Provides a one-entry output register, fair arbitration, a flush input and a grant index for tagging.

---
 rtl/rr_mux_reg.sv | 93 +++++++++
 tb/tb_rr_mux_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_reg.sv
// N-way round-robin merge of valid/ready channels into one registered output stage.
// Grant scanning starts at the priority pointer, which moves past each accepted channel.
module rr_mux_reg #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Flush,
  input  logic [N-1:0]       InValid,
  input  logic [N*WIDTH-1:0] InData,
  output logic [N-1:0]       InReady,
  output logic               OutValid,
  output logic [WIDTH-1:0]   OutData,
  output logic [SELW-1:0]    OutSel,
  input  logic               OutReady
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SELW-1:0]   out_sel_q,   out_sel_d;
  logic [SELW-1:0]   ptr_q,       ptr_d;

  logic              grant_v;
  logic [SELW-1:0]   grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic              accept;

  // Lowest valid index at or above the pointer wins; otherwise lowest below it.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (InValid[i] && (i < int'(ptr_q))) begin
        grant_v   = 1'b1;
        grant_idx = SELW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (InValid[i] && (i >= int'(ptr_q))) begin
        grant_v   = 1'b1;
        grant_idx = SELW'(i);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_data = InData[i*WIDTH +: WIDTH];
    end
  end

  assign accept  = grant_v && (!out_valid_q || OutReady) && !Flush && !reset;
  assign InReady = accept ? (N'(1) << grant_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (Flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      ptr_d       = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OutValid = out_valid_q;
  assign OutData  = out_data_q;
  assign OutSel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: a per-cycle vector table on a 4-way instance,
// plus hand sequences for reset, mid-operation reset and a 3-way wrap case.
module tb_rr_mux_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush4;
  logic [3:0]   iv4;
  logic [127:0] id4;
  logic [3:0]   ir4;
  logic         ov4;
  logic [31:0]  od4;
  logic [1:0]   os4;
  logic         or4;
  logic [31:0]  d0;

  logic         flush3;
  logic [2:0]   iv3;
  logic [95:0]  id3;
  logic [2:0]   ir3;
  logic         ov3;
  logic [31:0]  od3;
  logic [1:0]   os3;
  logic         or3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign id4 = {32'hA3, 32'hA2, 32'hA1, d0};
  assign id3 = {32'hB2, 32'hB1, 32'hB0};

  rr_mux_reg #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .reset(reset), .Flush(flush4), .InValid(iv4), .InData(id4),
    .InReady(ir4), .OutValid(ov4), .OutData(od4), .OutSel(os4), .OutReady(or4)
  );

  rr_mux_reg #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .reset(reset), .Flush(flush3), .InValid(iv3), .InData(id3),
    .InReady(ir3), .OutValid(ov3), .OutData(od3), .OutSel(os3), .OutReady(or3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs checked before each edge reflect state left by earlier vectors;
  // exp_ir is the combinational InReady for this vector's inputs.
  typedef struct {
    logic        flush;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] d0;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic [1:0]  exp_os;
  } vec_t;

  vec_t vecs [19];
  logic [2:0] exp_ir3 [4];
  logic [1:0] exp_os3 [4];

  initial begin
    vecs[0]  = '{1'b0, 4'b1111, 1'b1, 32'hA0, 4'b0001, 1'b0, 32'h0,  2'd0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 32'hA0, 4'b0010, 1'b1, 32'hA0, 2'd0};
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 32'hA0, 4'b0100, 1'b1, 32'hA1, 2'd1};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 32'hA0, 4'b1000, 1'b1, 32'hA2, 2'd2};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 32'hA0, 4'b0001, 1'b1, 32'hA3, 2'd3};
    vecs[5]  = '{1'b0, 4'b0100, 1'b0, 32'hA0, 4'b0000, 1'b1, 32'hA0, 2'd0};
    vecs[6]  = '{1'b0, 4'b0100, 1'b0, 32'hA0, 4'b0000, 1'b1, 32'hA0, 2'd0};
    vecs[7]  = '{1'b0, 4'b0100, 1'b0, 32'hA0, 4'b0000, 1'b1, 32'hA0, 2'd0};
    vecs[8]  = '{1'b0, 4'b0100, 1'b1, 32'hA0, 4'b0100, 1'b1, 32'hA0, 2'd0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 32'hA0, 4'b0000, 1'b1, 32'hA2, 2'd2};
    vecs[10] = '{1'b0, 4'b0000, 1'b0, 32'hA0, 4'b0000, 1'b0, 32'hA2, 2'd2};
    vecs[11] = '{1'b0, 4'b0001, 1'b0, 32'h55, 4'b0001, 1'b0, 32'hA2, 2'd2};
    vecs[12] = '{1'b1, 4'b0001, 1'b0, 32'h66, 4'b0000, 1'b1, 32'h55, 2'd0};
    vecs[13] = '{1'b0, 4'b0001, 1'b0, 32'h66, 4'b0001, 1'b0, 32'h55, 2'd0};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 32'h66, 4'b0000, 1'b1, 32'h66, 2'd0};
    vecs[15] = '{1'b0, 4'b1001, 1'b0, 32'h66, 4'b1000, 1'b0, 32'h66, 2'd0};
    vecs[16] = '{1'b0, 4'b1001, 1'b0, 32'h66, 4'b0000, 1'b1, 32'hA3, 2'd3};
    vecs[17] = '{1'b0, 4'b1001, 1'b1, 32'h66, 4'b0001, 1'b1, 32'hA3, 2'd3};
    vecs[18] = '{1'b0, 4'b0000, 1'b1, 32'h66, 4'b0000, 1'b1, 32'h66, 2'd0};

    exp_ir3[0] = 3'b001; exp_os3[0] = 2'd2;
    exp_ir3[1] = 3'b010; exp_os3[1] = 2'd0;
    exp_ir3[2] = 3'b100; exp_os3[2] = 2'd1;
    exp_ir3[3] = 3'b001; exp_os3[3] = 2'd2;

    reset = 1'b1; flush4 = 1'b0; iv4 = 4'b1111; or4 = 1'b0; d0 = 32'hA0;
    flush3 = 1'b0; iv3 = 3'b000; or3 = 1'b0;

    @(negedge clk); #1;
    chk("reset_ir_c1", 64'(ir4), 64'h0);
    @(negedge clk); #1;
    chk("reset_ir_c2", 64'(ir4), 64'h0);
    reset = 1'b0; iv4 = 4'b0000;
    #1;
    chk("reset_ov", 64'(ov4), 64'h0);
    chk("reset_os", 64'(os4), 64'h0);
    chk("reset_od", 64'(od4), 64'h0);

    for (int v = 0; v < 19; v++) begin
      @(negedge clk);
      flush4 = vecs[v].flush; iv4 = vecs[v].iv; or4 = vecs[v].ordy; d0 = vecs[v].d0;
      #1;
      chk($sformatf("vec%0d_ir", v), 64'(ir4), 64'(vecs[v].exp_ir));
      chk($sformatf("vec%0d_ov", v), 64'(ov4), 64'(vecs[v].exp_ov));
      chk($sformatf("vec%0d_od", v), 64'(od4), 64'(vecs[v].exp_od));
      chk($sformatf("vec%0d_os", v), 64'(os4), 64'(vecs[v].exp_os));
    end

    // Mid-operation reset: hold ch1's item under backpressure (pointer -> 2), then reset.
    @(negedge clk);
    flush4 = 1'b0; iv4 = 4'b0010; or4 = 1'b0;
    #1;
    chk("mid_ir_ch1", 64'(ir4), 64'b0010);
    @(negedge clk);
    reset = 1'b1; iv4 = 4'b1111;
    #1;
    chk("mid_held_ov", 64'(ov4), 64'h1);
    chk("mid_held_os", 64'(os4), 64'd1);
    chk("mid_reset_ir", 64'(ir4), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_after_ov", 64'(ov4), 64'h0);
    chk("mid_after_od", 64'(od4), 64'h0);
    chk("mid_after_os", 64'(os4), 64'h0);
    chk("mid_after_ir", 64'(ir4), 64'b0001);
    @(negedge clk);
    iv4 = 4'b0000;
    #1;
    chk("mid_grant_ov", 64'(ov4), 64'h1);
    chk("mid_grant_os", 64'(os4), 64'h0);
    chk("mid_grant_od", 64'(od4), 64'h66);

    // Three-way instance: ch2 alone moves the pointer to 0, then all valid.
    @(negedge clk);
    reset = 1'b1; iv3 = 3'b100; or3 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("n3_first_ir", 64'(ir3), 64'b100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      iv3 = 3'b111;
      #1;
      chk($sformatf("n3_ir%0d", k), 64'(ir3), 64'(exp_ir3[k]));
      chk($sformatf("n3_os%0d", k), 64'(os3), 64'(exp_os3[k]));
      chk($sformatf("n3_ov%0d", k), 64'(ov3), 64'h1);
      chk($sformatf("n3_range%0d", k), 64'(os3 == 2'd3), 64'h0);
    end
    @(negedge clk);
    iv3 = 3'b000;
    #1;
    chk("n3_last_os", 64'(os3), 64'h0);
    chk("n3_last_od", 64'(od3), 64'hB0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
